sequence_scan_ctrl: RTL and testbench



---
 rtl/sequence_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_sequence_scan_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sequence_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sequence_scan_ctrl: serialises a word MSB-first into an external 1011
// detector and counts its hits. Optional first_pos output: SEQ_SCAN_FIRSTPOS_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module sequence_scan_ctrl #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ser_bit,
  output logic              det_clr,
  input  logic              det_hit,
  output logic [CNT_W-1:0]  hit_count,
  output logic              done,
  output logic              busy
`ifdef SEQ_SCAN_FIRSTPOS_EN
  ,
  output logic [4:0]        first_pos
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int             IDX_W    = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                hit_take;
`ifdef SEQ_SCAN_FIRSTPOS_EN
  logic [4:0]          fp_q, fp_d;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
`ifdef SEQ_SCAN_FIRSTPOS_EN
      fp_q    <= 5'h1F;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
`ifdef SEQ_SCAN_FIRSTPOS_EN
      fp_q    <= fp_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
`ifdef SEQ_SCAN_FIRSTPOS_EN
    fp_d       = fp_q;
`endif
    word_ready = 1'b0;
    ser_bit    = 1'b0;
    det_clr    = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    hit_take   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy       = 1'b0;
        word_ready = 1'b1;
        if (word_valid) begin
          shreg_d = word_in;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef SEQ_SCAN_FIRSTPOS_EN
          fp_d    = 5'h1F;
`endif
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        det_clr = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        ser_bit = shreg_q[WORD_W-1];
        shreg_d = shreg_q << 1;
        idx_d   = idx_q + IDX_W'(1);
        // Moore detector lags one cycle: index 0 still shows the cleared state.
        hit_take = det_hit && (idx_q != '0);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        hit_take = det_hit;
        state_d  = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (hit_take) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQ_SCAN_FIRSTPOS_EN
      if (fp_q == 5'h1F) fp_d = (state_q == S_DRAIN) ? LAST_IDX : (idx_q - IDX_W'(1));
`endif
    end

    // Hold the detector cleared and the handshake quiet while in reset.
    if (!reset) begin
      word_ready = 1'b0;
      ser_bit    = 1'b0;
      det_clr    = 1'b1;
      done       = 1'b0;
      busy       = 1'b0;
    end
  end

  assign hit_count = cnt_q;
`ifdef SEQ_SCAN_FIRSTPOS_EN
  assign first_pos = fp_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sequence_scan_ctrl.sv
`default_nettype none
// tb_sequence_scan_ctrl: directed stimulus, behavioural 1011 detector,
// scoreboard of expected hit counts popped on each done pulse.
module tb_sequence_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ready, ser_bit, det_clr, det_hit, done, busy;
  logic [4:0]  hit_count;
  logic        word_ready2, ser_bit2, det_clr2, done2, busy2;
  logic [1:0]  hit_count2;
`ifdef SEQ_SCAN_FIRSTPOS_EN
  logic [4:0]  first_pos, first_pos2;
`endif

  always #5 clock = ~clock;

  sequence_scan_ctrl #(.WORD_W(16), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .ser_bit(ser_bit), .det_clr(det_clr),
    .det_hit(det_hit), .hit_count(hit_count), .done(done), .busy(busy)
`ifdef SEQ_SCAN_FIRSTPOS_EN
    , .first_pos(first_pos)
`endif
  );

  // Narrow counter copy exposes saturation.
  sequence_scan_ctrl #(.WORD_W(16), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready2), .ser_bit(ser_bit2), .det_clr(det_clr2),
    .det_hit(det_hit), .hit_count(hit_count2), .done(done2), .busy(busy2)
`ifdef SEQ_SCAN_FIRSTPOS_EN
    , .first_pos(first_pos2)
`endif
  );

  // Moore overlapping 1011 detector with synchronous clear.
  logic [3:0] hist;
  always @(posedge clock) begin
    if (det_clr) hist <= 4'b0000;
    else         hist <= {hist[2:0], ser_bit};
  end
  assign det_hit = (hist == 4'b1011);

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int acc_hist[$];

  typedef struct {
    int hc;
    int fp;
    int acc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    total++;
    assert (obs === 32'(expv)) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void model(input logic [15:0] w, output int hc, output int fp);
    logic [3:0] h;
    h  = 4'b0000;
    hc = 0;
    fp = 31;
    for (int i = 0; i < 16; i++) begin
      h = {h[2:0], w[15-i]};
      if (h == 4'b1011) begin
        hc++;
        if (fp == 31) fp = i;
      end
    end
  endfunction

  always @(posedge clock) cyc++;

  logic prev_acc = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      prev_acc = 1'b0;
    end else begin
      if (prev_acc) chk("hit_count_zero_on_accept", 32'(hit_count), 0);
      if (word_ready && busy) chk("ready_while_busy", 32'(1), 0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(1), 0);
        end else begin
          e = sb.pop_front();
          chk("hit_count", 32'(hit_count), e.hc);
          chk("hit_count_sat", 32'(hit_count2), (e.hc > 3) ? 3 : e.hc);
`ifdef SEQ_SCAN_FIRSTPOS_EN
          chk("first_pos", 32'(first_pos), e.fp);
`endif
          chk("done_latency", 32'(cyc - e.acc), 19);
        end
        done_cnt++;
      end
      prev_acc = word_ready && word_valid;
      if (prev_acc) begin
        model(word_in, e.hc, e.fp);
        e.acc = cyc;
        sb.push_back(e);
        acc_hist.push_back(cyc);
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    @(posedge clock); #1;
    while (!word_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 100) chk("ready_timeout", 32'(0), 1);
    word_in    = w;
    word_valid = 1'b1;
    @(posedge clock); #1;
    word_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 60) begin
      @(posedge clock);
      n++;
    end
    chk("done_seen", 32'(done_cnt >= target), 1);
    @(posedge clock); #1;
  endtask

  initial begin
    int d;
    int a;
    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_word_ready", 32'(word_ready), 0);
    chk("rst_det_clr",    32'(det_clr), 1);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_done",       32'(done), 0);
    chk("rst_ser_bit",    32'(ser_bit), 0);
    chk("rst_hit_count",  32'(hit_count), 0);
`ifdef SEQ_SCAN_FIRSTPOS_EN
    chk("rst_first_pos",  32'(first_pos), 31);
`endif
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("idle_word_ready", 32'(word_ready), 1);

    send(16'hB000); wait_done(1);
    send(16'h0000); wait_done(2);
    send(16'hBBBB); wait_done(3);
    repeat (3) @(posedge clock);
    #1;
    chk("hit_count_hold", 32'(hit_count), 4);
    chk("idle_busy", 32'(busy), 0);
    send(16'hB600); wait_done(4);

    // Abort in SHIFT index 8 (cycle 10 after accept; send returns in cycle 1)
    send(16'hB000);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_det_clr",    32'(det_clr), 1);
    chk("abort_busy",       32'(busy), 0);
    chk("abort_word_ready", 32'(word_ready), 0);
    chk("abort_done",       32'(done), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("abort_idle_busy",  32'(busy), 0);
    chk("abort_idle_ready", 32'(word_ready), 1);
    d = done_cnt;
    repeat (25) @(posedge clock);
    chk("abort_no_done", 32'(done_cnt), d);
    send(16'hB000); wait_done(d + 1);

    // word_valid held high with a constant word
    a = acc_cnt;
    @(posedge clock); #1;
    word_in    = 16'hB000;
    word_valid = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    word_valid = 1'b0;
    chk("hold_accepts", 32'(acc_cnt - a), 2);
    wait_done(d + 3);
    chk("hold_accept_gap", 32'(acc_hist[acc_hist.size()-1] - acc_hist[acc_hist.size()-2]), 20);
    repeat (5) @(posedge clock);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
